// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared types, constants and index helper for the LED sequencer
package led_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LIGHT = 2'd1,
        GAP   = 2'd2
    } seq_state_t;

    localparam int N_LED     = 4;
    localparam int DUR_DEF0  = 1;
    localparam int DUR_DEF1  = 2;
    localparam int DUR_DEF2  = 3;
    localparam int DUR_DEF3  = 4;

    function automatic int dur_default(input int i);
        case (i)
            0:       return DUR_DEF0;
            1:       return DUR_DEF1;
            2:       return DUR_DEF2;
            default: return DUR_DEF3;
        endcase
    endfunction

    // Lowest set bit of mask at or above 'from'; result is {found, index}.
    // 'from' is 3 bits so that "one past the last LED" (4) finds nothing.
    function automatic logic [2:0] first_set(input logic [N_LED-1:0] mask,
                                             input logic [2:0]       from);
        logic [2:0] r;
        r = '0;
        for (int i = N_LED - 1; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= from)) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - prescaler emitting a one-cycle tick every TICK_CYCLES clocks
// Ports: clk, rst_n (async, active-low); clr synchronously restarts the period;
//        tick is high for one cycle at the end of each period, never while clr.
module led_tick_gen #(
    parameter int TICK_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [CW-1:0] cnt;
    logic          at_end;

    assign at_end = (cnt == CW'(TICK_CYCLES - 1));
    assign tick   = at_end && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || at_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - start/stop sequencer lighting LED0..LED3 in turn for programmed tick counts
// Ports: clk, rst_n (async, active-low); start/stop one-cycle controls; loop_en level;
//        cfg_we/cfg_addr/cfg_data duration register write; led0..led3 active-low drives;
//        busy (not IDLE); done (end-of-sequence pulse); cur_led (lit index, 0 otherwise).
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int TICK_CYCLES = 50000000,
    parameter int DUR_W       = 4,
    parameter int GAP_TICKS   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [DUR_W-1:0] cfg_data,
    output logic             led0,
    output logic             led1,
    output logic             led2,
    output logic             led3,
    output logic             busy,
    output logic             done,
    output logic [1:0]       cur_led
);

    // The tick counter serves both LED durations and the gap, so it must hold either.
    localparam int GAP_W = $clog2(GAP_TICKS + 1);
    localparam int CNT_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    logic [DUR_W-1:0] dur [N_LED];
    logic [DUR_W-1:0] sh  [N_LED];

    seq_state_t       state, state_n;
    logic [1:0]       idx, idx_n;
    logic [CNT_W-1:0] tcnt;
    logic [N_LED-1:0] led_q, led_n;
    logic [1:0]       cur_q, cur_n;
    logic             done_q, done_n;
    logic             load_sh, step, advance;
    logic [N_LED-1:0] dur_nz, sh_nz;
    logic [2:0]       first_dur, next_sh;
    logic             tick, presc_clr, sh_last, gap_last;

    assign presc_clr = (state == IDLE) || stop;

    led_tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (presc_clr),
        .tick (tick)
    );

    always_comb begin
        dur_nz = '0;
        sh_nz  = '0;
        for (int i = 0; i < N_LED; i++) begin
            dur_nz[i] = |dur[i];
            sh_nz[i]  = |sh[i];
        end
    end

    assign first_dur = first_set(dur_nz, 3'd0);
    assign next_sh   = first_set(sh_nz, {1'b0, idx} + 3'd1);
    assign sh_last   = (tcnt == CNT_W'(sh[idx]) - CNT_W'(1));
    assign gap_last  = (tcnt == GAP_LAST);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        done_n  = 1'b0;
        load_sh = 1'b0;
        step    = 1'b0;
        advance = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    load_sh = 1'b1;
                    if (first_dur[2]) begin
                        state_n = LIGHT;
                        idx_n   = first_dur[1:0];
                        step    = 1'b1;
                    end else begin
                        done_n  = 1'b1;
                    end
                end
            end
            LIGHT: begin
                if (tick && sh_last) begin
                    step = 1'b1;
                    if (GAP_TICKS != 0) begin
                        state_n = GAP;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            GAP: begin
                if (tick && gap_last) begin
                    step    = 1'b1;
                    advance = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = 2'd0;
            end
        endcase

        // Move to the next nonzero LED, or wrap/finish when none remains.
        if (advance) begin
            if (next_sh[2]) begin
                state_n = LIGHT;
                idx_n   = next_sh[1:0];
            end else if (loop_en && first_dur[2]) begin
                load_sh = 1'b1;
                state_n = LIGHT;
                idx_n   = first_dur[1:0];
            end else begin
                load_sh = loop_en;
                state_n = IDLE;
                idx_n   = 2'd0;
                done_n  = 1'b1;
            end
        end

        if (stop) begin
            state_n = IDLE;
            idx_n   = 2'd0;
            done_n  = 1'b0;
            load_sh = 1'b0;
        end
    end

    always_comb begin
        led_n = '1;
        cur_n = 2'd0;
        if (state_n == LIGHT) begin
            led_n[idx_n] = 1'b0;
            cur_n        = idx_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= 2'd0;
            tcnt   <= '0;
            led_q  <= '1;
            cur_q  <= 2'd0;
            done_q <= 1'b0;
            for (int i = 0; i < N_LED; i++) begin
                dur[i] <= DUR_W'(dur_default(i));
                sh[i]  <= '0;
            end
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            led_q  <= led_n;
            cur_q  <= cur_n;
            done_q <= done_n;

            if ((state_n == IDLE) || step) begin
                tcnt <= '0;
            end else if (tick) begin
                tcnt <= tcnt + CNT_W'(1);
            end

            // The shadow copy takes the register values present before any same-edge write.
            if (load_sh) begin
                for (int i = 0; i < N_LED; i++) begin
                    sh[i] <= dur[i];
                end
            end

            if (cfg_we) begin
                dur[cfg_addr] <= cfg_data;
            end
        end
    end

    assign led0    = led_q[0];
    assign led1    = led_q[1];
    assign led2    = led_q[2];
    assign led3    = led_q[3];
    assign busy    = (state != IDLE);
    assign done    = done_q;
    assign cur_led = cur_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - directed self-checking bench for led_seq_ctrl
module tb_led_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = 2'd0;
    logic [3:0] cfg_data = 4'd0;
    logic       led0, led1, led2, led3;
    logic       busy, done;
    logic [1:0] cur_led;

    int checks = 0;
    int errors = 0;

    int sg_led [8];
    int sg_s   [8];
    int sg_e   [8];

    led_seq_ctrl #(
        .TICK_CYCLES(4),
        .DUR_W      (4),
        .GAP_TICKS  (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .loop_en (loop_en),
        .cfg_we  (cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .led0    (led0),
        .led1    (led1),
        .led2    (led2),
        .led3    (led3),
        .busy    (busy),
        .done    (done),
        .cur_led (cur_led)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        cfg_addr = a;
        cfg_data = d;
        cfg_we   = 1'b1;
        cyc();
        cfg_we   = 1'b0;
    endtask

    task automatic set_seg(input int i, input int led, input int s, input int e);
        sg_led[i] = led;
        sg_s[i]   = s;
        sg_e[i]   = e;
    endtask

    // Start is sampled at edge 0; after each edge k the outputs are compared with
    // the segment table. p_* give the sample index after which a one-cycle
    // start/stop/cfg_we is driven (sampled at edge p_*+1); -1 disables it.
    task automatic run_seq(input int n_seg, input int last_k, input int done_edge,
                           input int busy_end, input int p_start, input int p_stop,
                           input int p_we);
        logic [3:0] exp_l;
        logic [1:0] exp_cur;
        start = 1'b1;
        for (int k = 0; k <= last_k; k++) begin
            cyc();
            exp_l   = 4'hF;
            exp_cur = 2'd0;
            for (int s = 0; s < n_seg; s++) begin
                if (k >= sg_s[s] && k < sg_e[s]) begin
                    exp_l[sg_led[s]] = 1'b0;
                    exp_cur          = 2'(sg_led[s]);
                end
            end
            chk("leds", k, {led3, led2, led1, led0}, exp_l);
            chk("cur_led", k, cur_led, exp_cur);
            chk("busy", k, busy, (k < busy_end) ? 1 : 0);
            chk("done", k, done, (k == done_edge) ? 1 : 0);
            start  = (k == p_start);
            stop   = (k == p_stop);
            cfg_we = (k == p_we);
        end
        start  = 1'b0;
        stop   = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic default_table();
        set_seg(0, 0, 0, 4);
        set_seg(1, 1, 8, 16);
        set_seg(2, 2, 20, 32);
        set_seg(3, 3, 36, 52);
    endtask

    initial begin
        // Reset state
        cyc();
        cyc();
        chk("rst_leds", 0, {led3, led2, led1, led0}, 4'hF);
        chk("rst_busy", 0, busy, 0);
        chk("rst_done", 0, done, 0);
        chk("rst_cur", 0, cur_led, 0);
        rst_n = 1'b1;
        cyc();

        // Default sequence, done after edge 56
        default_table();
        run_seq(4, 58, 56, 56, -1, -1, -1);

        // Start and stop together from IDLE: stays IDLE
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_busy", 0, busy, 0);
        chk("ss_leds", 0, {led3, led2, led1, led0}, 4'hF);
        chk("ss_done", 0, done, 0);
        cyc();
        chk("ss_done2", 1, done, 0);

        // Start while busy (sampled at edge 7) is ignored
        default_table();
        run_seq(4, 57, 56, 56, 6, -1, -1);

        // Skip LED1
        wr(2'd1, 4'd0);
        set_seg(0, 0, 0, 4);
        set_seg(1, 2, 8, 20);
        set_seg(2, 3, 24, 40);
        run_seq(3, 45, 44, 44, -1, -1, -1);
        wr(2'd1, 4'd2);

        // Abort at edge 10 during LED1, then restart at edge 12 from LED0
        set_seg(0, 0, 0, 4);
        set_seg(1, 1, 8, 10);
        run_seq(2, 11, -1, 10, -1, 9, -1);
        default_table();
        run_seq(4, 57, 56, 56, -1, -1, -1);

        // Loop with dur[0]=2 written mid-run (edge 11): second pass LED0 lasts 8 cycles
        loop_en  = 1'b1;
        cfg_addr = 2'd0;
        cfg_data = 4'd2;
        default_table();
        set_seg(4, 0, 56, 64);
        set_seg(5, 1, 68, 76);
        run_seq(6, 72, -1, 1000, -1, -1, 10);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("loop_stop_busy", 0, busy, 0);
        chk("loop_stop_done", 0, done, 0);
        loop_en = 1'b0;
        wr(2'd0, 4'd1);

        // All durations zero: only a done pulse, even with loop_en
        wr(2'd0, 4'd0);
        wr(2'd1, 4'd0);
        wr(2'd2, 4'd0);
        wr(2'd3, 4'd0);
        loop_en = 1'b1;
        run_seq(0, 3, 0, 0, -1, -1, -1);
        loop_en = 1'b0;

        // Reset mid-sequence restores outputs at once and dur[] to 1/2/3/4
        wr(2'd0, 4'd3);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        chk("pre_rst_leds", 2, {led3, led2, led1, led0}, 4'hE);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_leds", 0, {led3, led2, led1, led0}, 4'hF);
        chk("mid_rst_busy", 0, busy, 0);
        chk("mid_rst_cur", 0, cur_led, 0);
        chk("mid_rst_done", 0, done, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        default_table();
        run_seq(4, 57, 56, 56, -1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Programmable sequencer for the four board LEDs (active-low, 1 = off).
It drives a start/stop-controlled scan in which LED0..LED3 light in turn.
- Each LED is lit for a register-programmed number of ticks, then all LEDs go dark for a fixed gap.
- One tick is derived from the system clock by an internal prescaler.

It replaces free-running hard-wired LED timing in the top level and is configured by the board's control logic through a small write port.

## Interface
Parameters:
- TICK_CYCLES, 50000000, clock cycles per tick (≥2)
- DUR_W, 4, width of each duration register in ticks
- GAP_TICKS, 1, dark ticks after each lit LED (0 = no gap)

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  one-cycle request to begin a sequence; honoured only in IDLE
- stop  in  1  one-cycle abort; honoured in any state
- loop_en  in  1  level; when 1, the sequence repeats instead of finishing
- cfg_we  in  1  duration register write strobe
- cfg_addr  in  2  LED index of the register written
- cfg_data  in  DUR_W  duration in ticks; 0 = skip that LED
- led0, led1, led2, led3  out  1 each  LED drives, active-low, registered
- busy  out  1  1 when state ≠ IDLE
- done  out  1  one-cycle pulse when a non-looping sequence ends
- cur_led  out  2  index of the LED currently lit; 0 outside LIGHT

## Operation
- Duration registers dur[0..3] reset to 1, 2, 3, 4. A write takes effect at the next edge and is accepted in any state.
- On an accepted start, dur[] is copied into shadow registers sh[0..3]. The running sequence uses only sh[]; writes during a run affect the next start or loop reload.
- States:
  - IDLE: all LEDs 1.
  - LIGHT: exactly one LED is 0, namely led[cur_led].
  - GAP: all LEDs 1.
- IDLE→LIGHT on start. The first LED is the lowest index with a nonzero duration, selected from the dur[] values being latched.
- LIGHT→GAP after sh[idx] ticks. If GAP_TICKS = 0, go directly to the next LED instead.
- GAP→LIGHT after GAP_TICKS ticks, on the next higher index with nonzero sh. Zero entries are skipped within the same cycle.
- After the last nonzero LED and its gap:
  - if loop_en = 1: reload sh[] from dur[], then LIGHT on the first nonzero LED;
  - otherwise: done = 1 for one cycle, then IDLE.
- Start with all durations 0:
  - no LED lights;
  - done pulses the cycle after start;
  - the block stays in IDLE, even when loop_en = 1.
- The same rule applies at a loop reload: if the reloaded dur[] values are all 0, pulse done and go to IDLE.
- stop: next state is IDLE, all LEDs 1, no done pulse. If stop and start are asserted in the same cycle, stop wins.
- The prescaler clears on accepted start, on stop, and in IDLE. Within LIGHT/GAP the tick counter clears on every state or index change.

## Timing
- Reset values: led0..3 = 1, busy = 0, done = 0, cur_led = 0, state IDLE, prescaler and tick counter = 0.
- Start sampled at edge E: from E the selected LED is 0 and busy = 1, with a latency of one edge.
- An LED with duration d is low for exactly d·TICK_CYCLES cycles. Each gap lasts exactly GAP_TICKS·TICK_CYCLES cycles.
- Transitions between LEDs produce no extra idle cycles.
- done is high for the single cycle following the last gap's final edge. busy falls at the same edge that done rises.
- Reset asserted mid-sequence forces all outputs to their reset values immediately (asynchronous).
- Duration arithmetic is unsigned DUR_W bits; the maximum is 2^DUR_W − 1 ticks, with no wrap.

## Structure
- Package led_seq_pkg:
  - state enum {IDLE, LIGHT, GAP};
  - N_LED = 4;
  - default duration constants 1/2/3/4.
- Sub-module led_tick_gen: prescaler with synchronous clear that emits a one-cycle tick every TICK_CYCLES cycles.
- Top level contains the register file, shadow copy, FSM, tick counter and output registers.

## Test plan
All scenarios use TICK_CYCLES = 4 and GAP_TICKS = 1.
- Default sequence: after reset, start at edge 0 with loop_en = 0. Required response:
  - led0 low for edges 0–4, led1 for 8–16, led2 for 20–32, led3 for 36–52;
  - done high for the one cycle after edge 56, then busy = 0.
- Skip: write dur[1] = 0, then start. Required response: led0 low 0–4, led2 low 8–20, led3 low 24–40; led1 never low; done after edge 44.
- Loop: loop_en = 1 with default durations. Required response: led0 falls again at edge 56 and no done pulse occurs. Writing dur[0] = 2 mid-run makes the second pass light led0 for 8 cycles.
- Abort: stop at edge 10 (during led1). Required response: all LEDs 1 and busy = 0 at edge 10, no done pulse, and a start at edge 12 restarts from led0.
- Edge cases:
  - start while busy: ignored, with no sequence change;
  - start and stop in the same cycle from IDLE: the block stays IDLE;
  - all durations 0: start yields only a done pulse, with the LEDs untouched.
- Reset mid-sequence: rst_n low at a non-edge time during LIGHT. Required response: LEDs go to 1 immediately and dur[] returns to 1/2/3/4.
